// File: rtl/dram_ecc_pkg.sv
// dram_ecc_pkg: shared widths, controller states and the SECDED(72,64) codec.
package dram_ecc_pkg;

  localparam int DATA_W = 64;
  localparam int CW_W   = 72;
  localparam int SYN_W  = 7;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_RD1  = 3'd2,
    ST_RD2  = 3'd3,
    ST_RESP = 3'd4
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [SYN_W-1:0]  syndrome;
    logic              corr;
    logic              uncorr;
  } secded_dec_t;

  // Powers of two (1,2,4,...,64) carry check bits; every other nonzero position carries data.
  function automatic logic is_check_pos(input int pos);
    return (pos & (pos - 1)) == 0;
  endfunction

  // Data fills non-check positions in ascending order, then each check bit
  // covers the positions whose index has its bit set; bit 0 is overall parity.
  function automatic logic [CW_W-1:0] secded_encode(input logic [DATA_W-1:0] data);
    logic [CW_W-1:0] cw;
    logic            par;
    int              j;
    int              cpos;
    cw = '0;
    j  = 0;
    for (int i = 1; i < CW_W; i++) begin
      if (!is_check_pos(i)) begin
        cw[i[6:0]] = data[j[5:0]];
        j++;
      end
    end
    for (int k = 0; k < SYN_W; k++) begin
      par = 1'b0;
      for (int i = 1; i < CW_W; i++) begin
        if (((i >> k) & 1) != 0) begin
          par = par ^ cw[i[6:0]];
        end
      end
      cpos = 1 << k;
      cw[cpos[6:0]] = par;
    end
    cw[0] = ^cw[CW_W-1:1];
    return cw;
  endfunction

  // Syndrome points at the flipped position when overall parity is odd;
  // even parity with a nonzero syndrome, or an out-of-range syndrome, is
  // uncorrectable and the raw data bits are passed through untouched.
  function automatic secded_dec_t secded_decode(input logic [CW_W-1:0] cw);
    secded_dec_t      res;
    logic [CW_W-1:0]  fixed;
    logic [SYN_W-1:0] syn;
    logic             par;
    int               j;
    syn = '0;
    for (int k = 0; k < SYN_W; k++) begin
      for (int i = 1; i < CW_W; i++) begin
        if (((i >> k) & 1) != 0) begin
          syn[k[2:0]] = syn[k[2:0]] ^ cw[i[6:0]];
        end
      end
    end
    par   = ^cw;
    fixed = cw;
    res   = '0;
    if (par) begin
      if (syn < 7'(CW_W)) begin
        fixed[syn] = ~fixed[syn];
        res.corr   = 1'b1;
      end else begin
        res.uncorr = 1'b1;
      end
    end else if (syn != '0) begin
      res.uncorr = 1'b1;
    end
    j = 0;
    for (int i = 1; i < CW_W; i++) begin
      if (!is_check_pos(i)) begin
        res.data[j[5:0]] = fixed[i[6:0]];
        j++;
      end
    end
    res.syndrome = syn;
    return res;
  endfunction

endpackage

// File: rtl/dram_ecc_ctrl_secded_72_64.sv
// secded_72_64: combinational SECDED(72,64) encoder and decoder pair.
module secded_72_64
  import dram_ecc_pkg::*;
(
  input  logic [DATA_W-1:0] enc_data,
  output logic [CW_W-1:0]   enc_cw,
  input  logic [CW_W-1:0]   dec_cw,
  output logic [DATA_W-1:0] dec_data,
  output logic [SYN_W-1:0]  dec_syndrome,
  output logic              dec_corr,
  output logic              dec_uncorr
);

  secded_dec_t dec_res;

  // Encoder and decoder are independent paths through the package codec.
  always_comb begin
    enc_cw  = secded_encode(enc_data);
    dec_res = secded_decode(dec_cw);
  end

  assign dec_data     = dec_res.data;
  assign dec_syndrome = dec_res.syndrome;
  assign dec_corr     = dec_res.corr;
  assign dec_uncorr   = dec_res.uncorr;

endmodule

// File: rtl/dram_ecc_ctrl.sv
// dram_ecc_ctrl: valid/ready front end to a 72-bit DRAM array with SECDED
// protection, single-bit scrub write-back and saturating error counters.
module dram_ecc_ctrl
  import dram_ecc_pkg::*;
#(
  parameter int ADDR_W = 2,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err_corr,
  output logic              rsp_err_uncorr,
  output logic [SYN_W-1:0]  rsp_syndrome,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [CW_W-1:0]   mem_wdata,
  output logic              mem_we,
  input  logic [CW_W-1:0]   mem_rdata
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e            state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_corr_q, rsp_err_corr_d;
  logic              rsp_err_uncorr_q, rsp_err_uncorr_d;
  logic [SYN_W-1:0]  rsp_syndrome_q, rsp_syndrome_d;
  logic [CNT_W-1:0]  corr_cnt_q, corr_cnt_d;
  logic [CNT_W-1:0]  uncorr_cnt_q, uncorr_cnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [CW_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;

  logic [DATA_W-1:0] enc_data;
  logic [CW_W-1:0]   enc_cw;
  logic [DATA_W-1:0] dec_data;
  logic [SYN_W-1:0]  dec_syndrome;
  logic              dec_corr;
  logic              dec_uncorr;
  logic              accept;

  secded_72_64 u_codec (
    .enc_data     (enc_data),
    .enc_cw       (enc_cw),
    .dec_cw       (mem_rdata),
    .dec_data     (dec_data),
    .dec_syndrome (dec_syndrome),
    .dec_corr     (dec_corr),
    .dec_uncorr   (dec_uncorr)
  );

  // One shared encoder: request data when idle, corrected read data for the scrub.
  always_comb begin
    enc_data = (state_q == ST_RD2) ? dec_data : req_wdata;
  end

  // The ready flop comes out of reset low and rises one cycle later; reset
  // also masks it so no request is taken while reset is held.
  assign req_ready = req_ready_q & ~reset;
  assign accept    = req_valid & req_ready;

  // Next-state and next-output computation for the controller.
  always_comb begin
    state_d          = state_q;
    rsp_valid_d      = rsp_valid_q;
    rsp_rdata_d      = rsp_rdata_q;
    rsp_err_corr_d   = rsp_err_corr_q;
    rsp_err_uncorr_d = rsp_err_uncorr_q;
    rsp_syndrome_d   = rsp_syndrome_q;
    corr_cnt_d       = corr_cnt_q;
    uncorr_cnt_d     = uncorr_cnt_q;
    mem_addr_d       = mem_addr_q;
    mem_wdata_d      = mem_wdata_q;
    mem_we_d         = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          mem_addr_d = req_addr;
          if (req_write) begin
            mem_wdata_d = enc_cw;
            mem_we_d    = 1'b1;
            state_d     = ST_WR;
          end else begin
            state_d = ST_RD1;
          end
        end
      end
      ST_WR: begin
        state_d          = ST_RESP;
        rsp_valid_d      = 1'b1;
        rsp_rdata_d      = '0;
        rsp_err_corr_d   = 1'b0;
        rsp_err_uncorr_d = 1'b0;
        rsp_syndrome_d   = '0;
      end
      ST_RD1: begin
        state_d = ST_RD2;
      end
      ST_RD2: begin
        state_d          = ST_RESP;
        rsp_valid_d      = 1'b1;
        rsp_rdata_d      = dec_data;
        rsp_err_corr_d   = dec_corr;
        rsp_err_uncorr_d = dec_uncorr;
        rsp_syndrome_d   = dec_syndrome;
        if (dec_corr) begin
          // Scrub: rewrite the corrected codeword in the first response cycle.
          mem_we_d    = 1'b1;
          mem_wdata_d = enc_cw;
          if (corr_cnt_q != CNT_MAX) begin
            corr_cnt_d = corr_cnt_q + CNT_W'(1);
          end
        end
        if (dec_uncorr && (uncorr_cnt_q != CNT_MAX)) begin
          uncorr_cnt_d = uncorr_cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d          = ST_IDLE;
          rsp_valid_d      = 1'b0;
          rsp_rdata_d      = '0;
          rsp_err_corr_d   = 1'b0;
          rsp_err_uncorr_d = 1'b0;
          rsp_syndrome_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    req_ready_d = (state_d == ST_IDLE);
  end

  // State and registered outputs; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      req_ready_q      <= 1'b0;
      rsp_valid_q      <= 1'b0;
      rsp_rdata_q      <= '0;
      rsp_err_corr_q   <= 1'b0;
      rsp_err_uncorr_q <= 1'b0;
      rsp_syndrome_q   <= '0;
      corr_cnt_q       <= '0;
      uncorr_cnt_q     <= '0;
      mem_addr_q       <= '0;
      mem_wdata_q      <= '0;
      mem_we_q         <= 1'b0;
    end else begin
      state_q          <= state_d;
      req_ready_q      <= req_ready_d;
      rsp_valid_q      <= rsp_valid_d;
      rsp_rdata_q      <= rsp_rdata_d;
      rsp_err_corr_q   <= rsp_err_corr_d;
      rsp_err_uncorr_q <= rsp_err_uncorr_d;
      rsp_syndrome_q   <= rsp_syndrome_d;
      corr_cnt_q       <= corr_cnt_d;
      uncorr_cnt_q     <= uncorr_cnt_d;
      mem_addr_q       <= mem_addr_d;
      mem_wdata_q      <= mem_wdata_d;
      mem_we_q         <= mem_we_d;
    end
  end

  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_err_corr   = rsp_err_corr_q;
  assign rsp_err_uncorr = rsp_err_uncorr_q;
  assign rsp_syndrome   = rsp_syndrome_q;
  assign corr_cnt       = corr_cnt_q;
  assign uncorr_cnt     = uncorr_cnt_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign mem_we         = mem_we_q;

endmodule

// File: tb/tb_dram_ecc_ctrl.sv
// tb_dram_ecc_ctrl: randomized and directed bench with a behavioural SECDED
// and timing model, plus a registered-output array model.
module tb_dram_ecc_ctrl;

  localparam int CNT_MAX = 255;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err_corr;
  logic        rsp_err_uncorr;
  logic [6:0]  rsp_syndrome;
  logic [7:0]  corr_cnt;
  logic [7:0]  uncorr_cnt;
  logic [1:0]  mem_addr;
  logic [71:0] mem_wdata;
  logic        mem_we;
  logic [71:0] mem_rdata = '0;

  always #5 clk = ~clk;

  dram_ecc_ctrl #(.ADDR_W(2), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err_corr(rsp_err_corr), .rsp_err_uncorr(rsp_err_uncorr),
    .rsp_syndrome(rsp_syndrome), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  // DRAM array: registered read port, plus an error-injection hook.
  logic [71:0] arr [4] = '{default: '0};
  logic        inj_en = 1'b0;
  logic [1:0]  inj_addr = '0;
  logic [71:0] inj_mask = '0;

  always @(posedge clk) begin
    if (mem_we) begin
      arr[mem_addr] <= mem_wdata;
    end else begin
      mem_rdata <= arr[mem_addr];
      if (inj_en) arr[inj_addr] <= arr[inj_addr] ^ inj_mask;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  // Expected state of the outputs for the current cycle, set by the driver.
  logic        chk_en = 1'b0;
  logic        exp_ready = 1'b0, exp_we = 1'b0, exp_rsp_valid = 1'b0;
  logic        exp_corr = 1'b0, exp_uncorr = 1'b0;
  logic [1:0]  exp_waddr = '0;
  logic [71:0] exp_wdata = '0;
  logic [63:0] exp_rdata = '0;
  logic [6:0]  exp_syn = '0;
  int          m_corr = 0, m_uncorr = 0;
  logic [71:0] model_mem [4] = '{default: '0};

  // Values observed mid-cycle for the literal checks.
  logic [63:0] cap_rdata;
  logic [6:0]  cap_syn;
  logic        cap_corr, cap_uncorr, cap_we;
  logic [71:0] cap_wdata, cap_wr_cw;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Behavioural code: each check bit is one bit of the XOR of the indices of all set data positions.
  function automatic logic [71:0] m_encode(input logic [63:0] d);
    logic [71:0] cw;
    logic [6:0]  acc;
    int          j;
    int          cp;
    cw = '0; acc = '0; j = 0;
    for (int i = 3; i < 72; i++) begin
      if ((i & (i - 1)) != 0) begin
        if (d[j[5:0]]) begin
          cw[i[6:0]] = 1'b1;
          acc = acc ^ i[6:0];
        end
        j++;
      end
    end
    for (int k = 0; k < 7; k++) begin
      cp = 1 << k;
      cw[cp[6:0]] = acc[k[2:0]];
    end
    cw[0] = ^cw[71:1];
    return cw;
  endfunction

  function automatic logic [63:0] m_extract(input logic [71:0] cw);
    logic [63:0] d;
    int          j;
    d = '0; j = 0;
    for (int i = 3; i < 72; i++) begin
      if ((i & (i - 1)) != 0) begin
        d[j[5:0]] = cw[i[6:0]];
        j++;
      end
    end
    return d;
  endfunction

  task automatic m_read(input logic [71:0] cw, output logic [63:0] d, output logic [6:0] s,
                        output logic c, output logic u);
    logic [6:0] acc;
    logic       p;
    acc = '0;
    for (int i = 1; i < 72; i++) if (cw[i[6:0]]) acc = acc ^ i[6:0];
    p = ^cw;
    s = acc; c = 1'b0; u = 1'b0;
    if (!p && acc == 0) d = m_extract(cw);
    else if (p && acc <= 7'd71) begin
      c = 1'b1;
      d = m_extract(cw ^ (72'h1 << acc));
    end else begin
      u = 1'b1;
      d = m_extract(cw);
    end
  endtask

  // Per-cycle compare of every output against the expectations.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", 72'(req_ready), 72'(exp_ready));
      chk("mem_we", 72'(mem_we), 72'(exp_we));
      if (exp_we) begin
        chk("mem_addr", 72'(mem_addr), 72'(exp_waddr));
        chk("mem_wdata", mem_wdata, exp_wdata);
      end
      chk("rsp_valid", 72'(rsp_valid), 72'(exp_rsp_valid));
      if (exp_rsp_valid) begin
        chk("rsp_rdata", 72'(rsp_rdata), 72'(exp_rdata));
        chk("rsp_err_corr", 72'(rsp_err_corr), 72'(exp_corr));
        chk("rsp_err_uncorr", 72'(rsp_err_uncorr), 72'(exp_uncorr));
        chk("rsp_syndrome", 72'(rsp_syndrome), 72'(exp_syn));
      end
      chk("corr_cnt", 72'(corr_cnt), 72'(m_corr));
      chk("uncorr_cnt", 72'(uncorr_cnt), 72'(m_uncorr));
    end
  end

  task automatic inject(input logic [1:0] addr, input logic [71:0] mask);
    inj_addr = addr; inj_mask = mask; inj_en = 1'b1;
    @(posedge clk); #1;
    inj_en = 1'b0;
    model_mem[addr] = model_mem[addr] ^ mask;
  endtask

  // One full request/response; called at posedge+1 of an idle cycle.
  task automatic do_op(input logic wr, input logic [1:0] addr, input logic [63:0] data,
                       input int hold, input logic hold_valid);
    logic [63:0] d;
    logic [6:0]  s;
    logic        c, u;
    logic [71:0] cw_w;
    m_read(model_mem[addr], d, s, c, u);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = data; rsp_ready = 1'b0;
    exp_ready = 1'b1; exp_we = 1'b0; exp_rsp_valid = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0; exp_ready = 1'b0;
    if (wr) begin
      cw_w = m_encode(data);
      exp_we = 1'b1; exp_waddr = addr; exp_wdata = cw_w;
      model_mem[addr] = cw_w;
      #2; cap_wr_cw = mem_wdata;
      @(posedge clk); #1;
      exp_we = 1'b0;
      exp_rdata = '0; exp_corr = 1'b0; exp_uncorr = 1'b0; exp_syn = '0;
    end else begin
      @(posedge clk); #1;
      @(posedge clk); #1;
      exp_rdata = d; exp_corr = c; exp_uncorr = u; exp_syn = s;
      if (c && m_corr < CNT_MAX) m_corr++;
      if (u && m_uncorr < CNT_MAX) m_uncorr++;
      exp_we = c;
      if (c) begin
        cw_w = m_encode(d);
        exp_waddr = addr; exp_wdata = cw_w;
        model_mem[addr] = cw_w;
      end
    end
    exp_rsp_valid = 1'b1;
    #2;
    cap_rdata = rsp_rdata; cap_syn = rsp_syndrome; cap_corr = rsp_err_corr;
    cap_uncorr = rsp_err_uncorr; cap_we = mem_we; cap_wdata = mem_wdata;
    for (int h = 0; h <= hold; h++) begin
      if (h == hold) begin
        rsp_ready = 1'b1; req_valid = 1'b0;
      end else begin
        rsp_ready = 1'b0; req_valid = hold_valid; req_write = 1'b1;
        req_addr = addr + 2'd1; req_wdata = {$urandom, $urandom};
      end
      @(posedge clk); #1;
      exp_we = 1'b0;
    end
    rsp_ready = 1'b0; exp_rsp_valid = 1'b0; exp_ready = 1'b1;
    chk("array_word", arr[addr], model_mem[addr]);
    $display("op wr=%0d addr=%0d rdata=%h corr=%0d uncorr=%0d syn=%0d", wr, addr,
             cap_rdata, cap_corr, cap_uncorr, cap_syn);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [71:0] mask;
    int          nflip;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; rsp_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2;
    chk("reset_req_ready", 72'(req_ready), 72'h0);
    chk("reset_rsp_valid", 72'(rsp_valid), 72'h0);
    chk("reset_mem_we", 72'(mem_we), 72'h0);
    chk("reset_counters", 72'({corr_cnt, uncorr_cnt}), 72'h0);
    chk("reset_mem_wdata", mem_wdata, 72'h0);
    @(posedge clk); #1;
    reset = 1'b0; exp_ready = 1'b0; chk_en = 1'b1;
    @(posedge clk); #1;
    exp_ready = 1'b1;

    // Read of a fresh array returns clean zero.
    do_op(1'b0, 2'd2, 64'h0, 0, 1'b0);
    chk("fresh_rdata", 72'(cap_rdata), 72'h0);
    chk("fresh_syn", 72'(cap_syn), 72'h0);
    chk("fresh_flags", 72'({cap_corr, cap_uncorr}), 72'h0);

    // Write / read-back.
    do_op(1'b1, 2'd1, 64'hDEADBEEF_CAFEF00D, 1, 1'b0);
    do_op(1'b0, 2'd1, 64'h0, 0, 1'b0);
    chk("wb_rdata", 72'(cap_rdata), 72'hDEADBEEF_CAFEF00D);
    chk("wb_corr", 72'(cap_corr), 72'h0);

    // Single-bit error at codeword bit 5, corrected and scrubbed.
    inject(2'd1, 72'h20);
    do_op(1'b0, 2'd1, 64'h0, 2, 1'b0);
    chk("sbe_syn", 72'(cap_syn), 72'd5);
    chk("sbe_corr", 72'(cap_corr), 72'h1);
    chk("sbe_rdata", 72'(cap_rdata), 72'hDEADBEEF_CAFEF00D);
    chk("sbe_scrub_we", 72'(cap_we), 72'h1);
    chk("sbe_scrub_cw", cap_wdata, m_encode(64'hDEADBEEF_CAFEF00D));
    chk("sbe_corr_cnt", 72'(corr_cnt), 72'd1);
    do_op(1'b0, 2'd1, 64'h0, 0, 1'b0);
    chk("after_scrub_corr", 72'(cap_corr), 72'h0);
    chk("after_scrub_syn", 72'(cap_syn), 72'h0);

    // Double-bit error at bits 3 and 10: raw data, no scrub.
    inject(2'd1, 72'h408);
    do_op(1'b0, 2'd1, 64'h0, 0, 1'b0);
    chk("dbe_uncorr", 72'(cap_uncorr), 72'h1);
    chk("dbe_syn", 72'(cap_syn), 72'd9);
    chk("dbe_rdata", 72'(cap_rdata), 72'hDEADBEEF_CAFEF02C);
    chk("dbe_no_scrub", 72'(cap_we), 72'h0);
    chk("dbe_uncorr_cnt", 72'(uncorr_cnt), 72'd1);

    // Encoding of data 1: data[0] at bit 3 sets c0, c1 and overall parity.
    do_op(1'b1, 2'd0, 64'h1, 0, 1'b0);
    chk("enc_one", cap_wr_cw, 72'hF);

    // Backpressure with a competing request held valid.
    do_op(1'b0, 2'd0, 64'h0, 5, 1'b1);
    chk("bp_rdata", 72'(cap_rdata), 72'h1);

    // Randomized traffic with random error injection.
    for (int n = 0; n < 150; n++) begin
      logic [1:0] a;
      a = 2'($urandom_range(3, 0));
      nflip = $urandom_range(5, 0);
      if (nflip >= 1 && nflip <= 3) begin
        mask = '0;
        for (int b = 0; b < nflip; b++) mask[7'($urandom_range(71, 0))] = 1'b1;
        inject(a, mask);
      end
      do_op(1'($urandom_range(1, 0)), a, {$urandom, $urandom},
            $urandom_range(3, 0), 1'($urandom_range(1, 0)));
    end

    // Reset in the decode cycle of a read that would have corrected an error.
    inject(2'd2, 72'h1 << 20);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 2'd2; exp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; exp_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    m_corr = 0; m_uncorr = 0;
    #2;
    chk("rst_mid_corr_cnt", 72'(corr_cnt), 72'h0);
    chk("rst_mid_rsp_valid", 72'(rsp_valid), 72'h0);
    chk("rst_mid_mem_we", 72'(mem_we), 72'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    exp_ready = 1'b1;
    chk("rst_mid_array", arr[2], model_mem[2]);

    // Counter saturation with a run of single-bit errors.
    do_op(1'b0, 2'd2, 64'h0, 0, 1'b0);
    chk("post_rst_corr_cnt", 72'(corr_cnt), 72'd1);
    for (int n = 0; n < 256; n++) begin
      inject(2'd3, 72'h1 << $urandom_range(71, 0));
      do_op(1'b0, 2'd3, 64'h0, 0, 1'b0);
    end
    chk("sat_corr_cnt", 72'(corr_cnt), 72'd255);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dram_ecc_ctrl.md
# dram_ecc_ctrl

SECDED memory controller between the datapath's 64-bit load/store port and the 4x72 DRAM array. Encodes 64-bit write data into 72-bit Hamming codewords and decodes/corrects read codewords. Counts corrected and uncorrectable errors. Writes the corrected codeword back to the array after a single-bit error (scrub). Exposes a valid/ready request/response interface upstream and drives the array's address, data-in and write/read-compare pins downstream.

## Interface
- `ADDR_W`, default 2: array address width; the array holds 4 words.
- `CNT_W`, default 8: width of the saturating error counters.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller can accept a request.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in ADDR_W: word address.
- `req_wdata` in 64: write data.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_rdata` out 64: corrected read data; 0 for a write ack.
- `rsp_err_corr` out 1: a single-bit error was corrected.
- `rsp_err_uncorr` out 1: a double or invalid error was detected.
- `rsp_syndrome` out 7: Hamming syndrome of the read.
- `corr_cnt` out CNT_W: saturating count of corrected errors.
- `uncorr_cnt` out CNT_W: saturating count of uncorrectable errors.
- `mem_addr` out ADDR_W: array address, registered.
- `mem_wdata` out 72: array data-in, registered.
- `mem_we` out 1: array write/read-compare pin (1 = write, 0 = read), registered.
- `mem_rdata` in 72: array data-out. The array registers this output: it updates at the clock edge after `mem_addr` is presented with `mem_we`=0.

## Operation
- **Codeword layout** (cw[71:0]):
  - Bit 0: overall even parity over all 72 bits.
  - Bits 1, 2, 4, 8, 16, 32, 64: check bits c0..c6.
  - The remaining 64 positions, ascending: data[0]..data[63]. data[0] is at bit 3; data[63] is at bit 71.
- **Encode:**
  - c_k = XOR of the data positions i whose index has bit k set.
  - cw[0] = XOR of cw[71:1].
  - All-zero data encodes to an all-zero codeword, so a freshly reset array reads clean.
- **Decode:**
  - s[k] = XOR of cw[i] for i in 1..71 with bit k of i set.
  - p = XOR of cw[71:0].
  - p=0, s=0: clean.
  - p=1, s≤71: flip bit s (bit 0 when s=0). Set corr.
  - p=0, s≠0: set uncorr.
  - p=1, s>71: set uncorr.
  - On uncorr, `rsp_rdata` carries the raw data bits, uncorrected.
- **States:**
  - IDLE: `req_ready`=1.
  - WR: write issued.
  - RD1: address presented.
  - RD2: `mem_rdata` valid; decode.
  - RESP: `rsp_valid`=1; hold until `rsp_ready`.
- **Transitions:**
  - IDLE → WR on accepted write; IDLE → RD1 on accepted read.
  - WR → RESP.
  - RD1 → RD2 → RESP.
  - RESP → IDLE on `rsp_valid` & `rsp_ready`.
- **Scrub:** when RD2 decodes corr, the controller writes the corrected codeword to the same address in the first RESP cycle (`mem_we`=1 for exactly one cycle). This happens independent of `rsp_ready`. No scrub on uncorr.
- **Counters:** increment at the RD2 edge and saturate at 2^CNT_W−1. Only `reset` clears them.
- `mem_we` is 0 at all times except WR and the scrub cycle.

## Timing
- Request accepted at edge N (`req_valid` & `req_ready`).
- **Write:**
  - `mem_we`=1 with encoded data during cycle N+1; the array writes at edge N+1.
  - `rsp_valid`=1 from cycle N+2.
- **Read:**
  - `mem_addr` driven in cycle N+1; the array registers at edge N+1.
  - Decode in cycle N+2.
  - `rsp_*` valid from cycle N+3.
  - Scrub write, if any, in cycle N+3.
- All `rsp_*` outputs hold stable while `rsp_valid`=1 and `rsp_ready`=0.
- The next request can be accepted no earlier than the cycle after the response handshake. Peak throughput is one op per 3 cycles for writes and 4 cycles for reads.
- **Reset values:** all outputs 0, state IDLE.
- `req_ready` is 0 while `reset` is asserted.
- Reset mid-operation aborts the operation: no response, and `mem_we`=0 after the reset edge.

## Structure
- Package `dram_ecc_pkg` contains:
  - Constants: DATA_W=64, CW_W=72, SYN_W=7.
  - The state enum.
  - Pure functions `secded_encode` and `secded_decode`, which return data, syndrome, corr and uncorr.
- Sub-module `secded_72_64`: combinational encoder/decoder pair wrapping the package functions. The FSM, registers and counters live in `dram_ecc_ctrl`.

## Test plan
- **Reset, then read:** reset 2 cycles, then read addr 2 → `rsp_valid` at N+3, `rsp_rdata`=0, corr=uncorr=0, syndrome=0, `mem_we` never asserted.
- **Write/read-back:** write addr 1 data 0xDEADBEEF_CAFEF00D → `mem_we`=1 only in cycle N+1, ack at N+2. Read addr 1 → same data, clean.
- **Single-bit error:** flip cw bit 5 of stored word → data correct, `rsp_err_corr`=1, `rsp_syndrome`=5, `corr_cnt`=1, scrub write of the clean codeword in cycle N+3. A second read returns clean.
- **Double-bit error:** flip bits 3 and 10 → `rsp_err_uncorr`=1, `uncorr_cnt`=1, no scrub write.
- **Backpressure:** `rsp_ready`=0 for 5 cycles with `req_valid`=1 → response stable, `req_ready`=0, no second op starts. `rsp_ready`=1 → IDLE the next cycle.
- **Reset mid-read:** assert reset in cycle N+2 of a read → no `rsp_valid`, counters 0, `mem_we`=0 on the next cycle. Also: 256 single-bit errors → `corr_cnt` saturates at 255.
